// File: rtl/fwd_sel_ctrl.sv
// Forwarding-select controller: tracks in-flight destination registers and drives
// registered EX operand-mux selects plus the load-use stall. Option: FWD_WB_BYPASS_EN.
module fwd_sel_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              load_stall
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;
`ifdef FWD_WB_BYPASS_EN
  localparam logic [1:0] SEL_WBD = 2'b11;
`endif

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } ex_slot_t;

  // Older slots only need the write tag; the load flag matters only in EX.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wr;
  } wr_slot_t;

  ex_slot_t   ex_q, ex_d;
  wr_slot_t   mem_q, mem_d;
`ifdef FWD_WB_BYPASS_EN
  // A producer in WB now sits in the WBD bypass register when the consumer reaches EX.
  wr_slot_t   wb_q, wb_d;
`endif
  logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;

  function automatic logic hit(input logic [REG_AW-1:0] src, input logic used,
                               input logic [REG_AW-1:0] rd, input logic wr);
    return used && (src != '0) && wr && (rd == src);
  endfunction

  function automatic logic [1:0] next_sel(input logic [REG_AW-1:0] src, input logic used);
    logic [1:0] s;
    s = SEL_RF;
    if (hit(src, used, ex_q.rd, ex_q.wr))        s = SEL_EXM;
    else if (hit(src, used, mem_q.rd, mem_q.wr)) s = SEL_MWB;
`ifdef FWD_WB_BYPASS_EN
    else if (hit(src, used, wb_q.rd, wb_q.wr))   s = SEL_WBD;
`endif
    return s;
  endfunction

  assign load_stall = ex_q.ld && (hit(id_rs1, id_rs1_used, ex_q.rd, ex_q.wr) ||
                                  hit(id_rs2, id_rs2_used, ex_q.rd, ex_q.wr));

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
`ifdef FWD_WB_BYPASS_EN
    wb_d    = wb_q;
`endif
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (!stall) begin
      mem_d = '{rd: ex_q.rd, wr: ex_q.wr};
`ifdef FWD_WB_BYPASS_EN
      wb_d  = mem_q;
`endif
      if (flush || load_stall) begin
        ex_d    = '0;
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
      end else begin
        ex_d    = '{rd: id_rd, wr: id_reg_write, ld: id_mem_read};
        sel_a_d = next_sel(id_rs1, id_rs1_used);
        sel_b_d = next_sel(id_rs2, id_rs2_used);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
`ifdef FWD_WB_BYPASS_EN
      wb_q    <= '0;
`endif
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
`ifdef FWD_WB_BYPASS_EN
      wb_q    <= wb_d;
`endif
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;

endmodule
